fetch_stage: RTL and testbench

Instruction fetch stage sitting directly upstream of the decode/control unit. Owns the program counter and issues sequential word requests to a synchronous-read instruction memory. Buffers returned instructions in a small FIFO and hands them to decode over a valid/ready handshake. Accepts branch/jump redirects that flush all stale work.

---
 rtl/fetch_stage_if.sv | 30 +++
 rtl/fetch_stage.sv | 89 ++++++++
 tb/tb_fetch_stage.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Bus between the fetch stage, the instruction memory and decode.
// master = fetch stage, slave = the surrounding memory/decode environment.
interface fetch_stage_if;
  // Handshakes:
  //   decode: a head instruction moves when if_valid & if_ready are both high at a
  //   rising edge. if_valid never depends on if_ready. if_instr/if_pc hold while
  //   if_valid=1 and if_ready=0.
  //   imem: imem_req is always accepted; imem_rdata is valid exactly one cycle later.
  //   redirect_valid is a one-cycle command with no ready.
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;

  modport master (
    input  redirect_valid, redirect_pc, imem_rdata, if_ready,
    output imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc4
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_rdata, if_ready,
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc4
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues word reads to a synchronous
// instruction memory, and buffers returned instructions for decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input logic          clk,
  input logic          reset,
  fetch_stage_if.master bus
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(BUF_DEPTH);
  localparam logic [CNT_W:0]   DEPTH_C = (CNT_W+1)'(BUF_DEPTH);

  logic [31:0]      pc;
  logic             inflight;
  logic [31:0]      inflight_pc;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [31:0]      buf_instr [BUF_DEPTH];
  logic [31:0]      buf_pc    [BUF_DEPTH];

  logic             pop;
  logic             push;
  logic             req;
  logic [CNT_W:0]   credit_used;

  // A request is only issued if its response is guaranteed a buffer slot,
  // counting the slot freed by a pop in this same cycle.
  assign credit_used = {1'b0, count} + {{CNT_W{1'b0}}, inflight} - {{CNT_W{1'b0}}, pop};
  assign req         = !reset && !bus.redirect_valid && (credit_used < DEPTH_C);
  assign push        = inflight && !bus.redirect_valid && !reset;

  assign bus.if_valid  = !reset && (count != '0) && !bus.redirect_valid;
  assign pop           = bus.if_valid && bus.if_ready;
  assign bus.imem_req  = req;
  assign bus.imem_addr = pc;
  assign bus.if_instr  = reset ? 32'h0 : buf_instr[rd_ptr];
  assign bus.if_pc     = reset ? 32'h0 : buf_pc[rd_ptr];
  assign bus.if_pc4    = bus.if_pc + 32'd4;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 32'h0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else if (bus.redirect_valid) begin
      // Flush everything, including the response arriving next cycle.
      pc       <= {bus.redirect_pc[31:2], 2'b00};
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      if (req) begin
        pc          <= pc + 32'd4;
        inflight    <= 1'b1;
        inflight_pc <= pc;
      end else begin
        inflight <= 1'b0;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr[wr_ptr] <= bus.imem_rdata;
      buf_pc[wr_ptr]    <= inflight_pc;
    end
  end

  // The credit rule makes overflow unreachable; firing here means it was broken.
  no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && count == FULL_C));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a cycle table for streaming, stall and
// redirects, plus hand sequences for reset wrap-around and mid-stream reset.
module tb_fetch_stage;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  fetch_stage_if bus1 ();
  fetch_stage_if bus2 ();

  fetch_stage #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) dut_wrap (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // instruction memory models: data returned equals the requested address
  always @(posedge clk) begin
    bus1.imem_rdata <= bus1.imem_addr;
    bus2.imem_rdata <= bus2.imem_addr;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        redir;
    logic [31:0] redir_pc;
    logic        rdy;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic redir, input logic [31:0] redir_pc, input logic rdy,
                     input logic exp_req, input logic [31:0] exp_addr,
                     input logic exp_valid, input logic [31:0] exp_pc);
    vec_t v;
    v.redir = redir; v.redir_pc = redir_pc; v.rdy = rdy;
    v.exp_req = exp_req; v.exp_addr = exp_addr;
    v.exp_valid = exp_valid; v.exp_pc = exp_pc;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: apply inputs just after the rising edge
  task automatic drive(input logic redir, input logic [31:0] redir_pc, input logic rdy);
    bus1.redirect_valid = redir;
    bus1.redirect_pc    = redir_pc;
    bus1.if_ready       = rdy;
  endtask

  task automatic check_outputs(input string tag, input logic exp_req, input logic [31:0] exp_addr,
                               input logic exp_valid, input logic [31:0] exp_pc);
    logic [31:0] pc4;
    pc4 = exp_pc + 32'd4;
    check({tag, " imem_req"}, {31'b0, bus1.imem_req}, {31'b0, exp_req});
    if (exp_req) check({tag, " imem_addr"}, bus1.imem_addr, exp_addr);
    check({tag, " if_valid"}, {31'b0, bus1.if_valid}, {31'b0, exp_valid});
    if (exp_valid) begin
      check({tag, " if_pc"}, bus1.if_pc, exp_pc);
      check({tag, " if_instr"}, bus1.if_instr, exp_pc);
      check({tag, " if_pc4"}, bus1.if_pc4, pc4);
    end
  endtask

  initial begin
    logic [31:0] wrap_pc;
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc    = 32'h0;
    bus2.if_ready       = 1'b1;
    drive(1'b0, 32'h0, 1'b1);
    reset = 1'b1;

    // streaming, 6-cycle stall, redirect (misaligned), back-to-back redirects
    add(0, 0, 1,  1, 32'h000, 0, 0);
    add(0, 0, 1,  1, 32'h004, 0, 0);
    for (int i = 0; i < 6; i++) add(0, 0, 0,  0, 0, 1, 32'h000);
    add(0, 0, 1,  1, 32'h008, 1, 32'h000);
    add(0, 0, 1,  1, 32'h00C, 1, 32'h004);
    add(0, 0, 1,  1, 32'h010, 1, 32'h008);
    add(0, 0, 1,  1, 32'h014, 1, 32'h00C);
    add(1, 32'h0000_0102, 1,  0, 0, 0, 0);
    add(0, 0, 1,  1, 32'h100, 0, 0);
    add(0, 0, 1,  1, 32'h104, 0, 0);
    add(0, 0, 1,  1, 32'h108, 1, 32'h100);
    add(0, 0, 1,  1, 32'h10C, 1, 32'h104);
    add(1, 32'h0000_0200, 1,  0, 0, 0, 0);
    add(1, 32'h0000_0300, 1,  0, 0, 0, 0);
    add(0, 0, 1,  1, 32'h300, 0, 0);
    add(0, 0, 1,  1, 32'h304, 0, 0);
    add(0, 0, 1,  1, 32'h308, 1, 32'h300);
    add(0, 0, 1,  1, 32'h30C, 1, 32'h304);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset imem_req", {31'b0, bus1.imem_req}, 32'h0);
    check("reset if_valid", {31'b0, bus1.if_valid}, 32'h0);
    check("reset if_pc", bus1.if_pc, 32'h0);
    check("reset if_instr", bus1.if_instr, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int k = 0; k < vq.size(); k++) begin
      drive(vq[k].redir, vq[k].redir_pc, vq[k].rdy);
      @(negedge clk);
      check_outputs($sformatf("row%0d", k), vq[k].exp_req, vq[k].exp_addr,
                    vq[k].exp_valid, vq[k].exp_pc);
      // wrap-around instance free-runs from the same reset release
      if (k == 0) check("wrap first addr", bus2.imem_addr, 32'hFFFF_FFF8);
      if (k >= 2 && k <= 4) begin
        wrap_pc = 32'hFFFF_FFF8 + 32'(4 * (k - 2));
        check($sformatf("wrap row%0d if_valid", k), {31'b0, bus2.if_valid}, 32'h1);
        check($sformatf("wrap row%0d if_pc", k), bus2.if_pc, wrap_pc);
        check($sformatf("wrap row%0d if_pc4", k), bus2.if_pc4, wrap_pc + 32'd4);
      end
      if (k == 3) check("wrap pc4 of FFFFFFFC", bus2.if_pc4, 32'h0);
      @(posedge clk); #1;
    end

    // fill the buffer by stalling, then reset for one cycle
    drive(1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check_outputs("fill0", 1'b0, 32'h0, 1'b1, 32'h308);
    @(posedge clk); #1;
    @(negedge clk);
    check_outputs("fill1", 1'b0, 32'h0, 1'b1, 32'h308);
    @(posedge clk); #1;
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b1);
    @(negedge clk);
    check("midreset imem_req", {31'b0, bus1.imem_req}, 32'h0);
    check("midreset if_valid", {31'b0, bus1.if_valid}, 32'h0);
    check("midreset if_pc", bus1.if_pc, 32'h0);
    check("midreset if_instr", bus1.if_instr, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_outputs("post0", 1'b1, 32'h000, 1'b0, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check_outputs("post1", 1'b1, 32'h004, 1'b0, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check_outputs("post2", 1'b1, 32'h008, 1'b1, 32'h000);
    @(posedge clk); #1;
    @(negedge clk);
    check_outputs("post3", 1'b1, 32'h00C, 1'b1, 32'h004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
